btn_debounce_blip: RTL and testbench
====================================

Name: btn_debounce_blip

Overview:
- Parametrised, multi-channel successor to the two-button press-pulse block.
- Per channel: 2-flop synchroniser, counter debounce, registered debounced level, one-cycle press pulse and one-cycle release pulse.
- Optional hold-to-repeat press pulses.
- Sits between board push-buttons and counter/UI logic in the Clk100M domain.

Parameters:
- NUM_BTN, 2: number of independent button channels (>=1).
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a new sampled value must persist before it is accepted (>=1; 10 ms at 100 MHz).
- REPEAT_DELAY, 50000000: cycles from press pulse to first repeat pulse (>=2; used only with BTN_AUTOREPEAT_EN).
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat pulses (>=1; used only with BTN_AUTOREPEAT_EN).

Ports:
- Clk100M  input  1  system clock; all state is rising-edge.
- Rst  input  1  reset, asynchronous, active-high.
- btn_raw  input  NUM_BTN  raw asynchronous button levels, 1 = pressed.
- btn_level  output  NUM_BTN  debounced level.
- btn_blip  output  NUM_BTN  one-cycle pulse on accepted press (plus repeats if enabled).
- btn_rel_blip  output  NUM_BTN  one-cycle pulse on accepted release.

Behaviour:
- Clocking and reset: one clock (Clk100M). Reset is asynchronous and active-high (Rst). While Rst=1, every flop is 0: sync stages, counters, btn_level, btn_blip, btn_rel_blip.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulse in the same cycle.
- Synchroniser: s1 <= btn_raw[i]; s2 <= s1.
- Debounce counter cnt: width clog2(DEBOUNCE_CYCLES), minimum 1 bit.
  - If s2 == btn_level[i]: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: btn_level[i] <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
- Glitch rejection: a single cycle with s2 equal to the current level restarts the count from 0.
- Pulses are registered and update on the same edge as btn_level:
  - btn_blip[i] is 1 for exactly one cycle when btn_level[i] goes 0->1.
  - btn_rel_blip[i] is 1 for exactly one cycle when btn_level[i] goes 1->0.
  - Otherwise both are 0. Never more than one press pulse per accepted press unless repeat is enabled.
- Latency: btn_raw changes before edge 0 and then holds. btn_level changes and the pulse asserts after edge DEBOUNCE_CYCLES+1, and the pulse deasserts after edge DEBOUNCE_CYCLES+2.
- Held input: no further pulses while the level is steady (without the macro).
- Reset mid-operation: all state cleared. If btn_raw is held high across reset deassertion, that is treated as a new press, with btn_blip after edge DEBOUNCE_CYCLES+1 counted from the first post-reset edge. No release pulse is generated by reset itself.
- Counters never wrap: cnt saturates logically at DEBOUNCE_CYCLES-1 and then clears.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Each channel adds repeat counter rcnt, width clog2(max(REPEAT_DELAY,REPEAT_PERIOD))+1, cleared whenever btn_level[i]=0 and on the press edge.
  - While btn_level[i]=1, rcnt increments each cycle.
  - With press pulse on edge P, extra one-cycle btn_blip pulses occur on edges P+REPEAT_DELAY, then P+REPEAT_DELAY+k*REPEAT_PERIOD for k>=1, until release.
  - Release stops repeats immediately; no repeat pulse coincides with btn_rel_blip.
- Undefined: rcnt logic is absent; exactly one btn_blip per press.

Test Plan (NUM_BTN=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3):
- Reset: Rst=1 with btn_raw=2'b11 -> all outputs 0 during reset. After deassert, btn_level=2'b11 and btn_blip=2'b11 after edge 5, btn_blip back to 2'b00 after edge 6.
- Clean press on ch0: raw set before edge 0, held 20 cycles -> btn_blip[0] high only in the cycle after edge 5, btn_level[0]=1 thereafter, btn_blip[1] and btn_rel_blip stay 0.
- Bounce: raw ch0 pattern 1,1,1,0,1,1,1,1,1 per cycle -> counter restarts at the 0. Single btn_blip[0] occurs 5 edges after the final rising sample, never two.
- Release: ch0 held high, then raw 0 held -> btn_rel_blip[0] exactly one cycle, btn_level[0] falls on the same edge, btn_blip[0] stays 0.
- Simultaneous: both raw bits rise on the same cycle -> btn_blip=2'b11 on one cycle. A 3-cycle pulse on ch1 only -> no change on ch1.
- BTN_AUTOREPEAT_EN: press at P, hold 20 cycles -> btn_blip[0] on P, P+8, P+11, P+14, P+17. Release -> no further btn_blip. Without the macro -> only P.

Source files
------------

// File: rtl/btn_debounce_blip.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce_blip
//  Purpose  : Multi-channel push-button conditioner. Each channel has a
//             2-flop synchroniser, a counter debouncer, a registered debounced
//             level, a one-cycle press pulse and a one-cycle release pulse.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk100M       in   1        system clock, rising edge
//    Rst           in   1        asynchronous reset, active high
//    btn_raw       in   NUM_BTN  raw asynchronous button levels (1 = pressed)
//    btn_level     out  NUM_BTN  debounced level
//    btn_blip      out  NUM_BTN  one-cycle pulse on accepted press
//                                (plus hold-to-repeat pulses when enabled)
//    btn_rel_blip  out  NUM_BTN  one-cycle pulse on accepted release
//  Build option
//    BTN_AUTOREPEAT_EN  when defined, a held button emits repeat press pulses
//                       REPEAT_DELAY cycles after the press pulse and every
//                       REPEAT_PERIOD cycles after that until release.
// ============================================================================
module btn_debounce_blip #(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic               Clk100M,
    input  logic               Rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_blip,
    output logic [NUM_BTN-1:0] btn_rel_blip
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam bit PARAMS_OK = (NUM_BTN >= 1) && (DEBOUNCE_CYCLES >= 1) &&
                               (REPEAT_DELAY >= 2) && (REPEAT_PERIOD >= 1);

    // Reject illegal configurations at elaboration.
    if (!PARAMS_OK) begin : g_param_err
        $error("btn_debounce_blip: illegal parameter value");
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W = $clog2(RMAX);
    localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        logic             s1_q, s2_q;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             blip_q, blip_d;
        logic             rel_q, rel_d;
        logic             accept;

        always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            accept  = 1'b0;
            if (s2_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                accept  = 1'b1;
                level_d = s2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        // rcnt_q = {phase, count}: phase 0 times the initial delay, phase 1
        // times each subsequent repeat period.
        logic [RC_W:0] rcnt_q, rcnt_d;
        logic          rep_fire;

        always_comb begin
            rcnt_d   = rcnt_q;
            rep_fire = 1'b0;
            if (!level_q || accept) begin
                rcnt_d = '0;
            end else if (rcnt_q[RC_W-1:0] == (rcnt_q[RC_W] ? PERIOD_LAST : DELAY_LAST)) begin
                rep_fire = 1'b1;
                rcnt_d   = {1'b1, {RC_W{1'b0}}};
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end

        // A release edge (accept while level_q=1) suppresses any coincident repeat.
        assign blip_d = (accept & ~level_q) | (rep_fire & ~accept);

        always_ff @(posedge Clk100M or posedge Rst) begin
            if (Rst) rcnt_q <= '0;
            else     rcnt_q <= rcnt_d;
        end
`else
        assign blip_d = accept & ~level_q;
`endif
        assign rel_d = accept & level_q;

        always_ff @(posedge Clk100M or posedge Rst) begin
            if (Rst) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                cnt_q   <= '0;
                level_q <= 1'b0;
                blip_q  <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                s1_q    <= btn_raw[i];
                s2_q    <= s1_q;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                blip_q  <= blip_d;
                rel_q   <= rel_d;
            end
        end

        assign btn_level[i]    = level_q;
        assign btn_blip[i]     = blip_q;
        assign btn_rel_blip[i] = rel_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_blip.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_btn_debounce_blip
//  Purpose  : Scoreboard bench for btn_debounce_blip (2 channels, debounce 4,
//             repeat delay 8, repeat period 3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_btn_debounce_blip;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic       Clk100M = 1'b0;
    logic       Rst     = 1'b1;
    logic [1:0] btn_raw = 2'b11;
    logic [1:0] btn_level, btn_blip, btn_rel_blip;

    btn_debounce_blip #(
        .NUM_BTN        (2),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .Clk100M     (Clk100M),
        .Rst         (Rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_blip    (btn_blip),
        .btn_rel_blip(btn_rel_blip)
    );

    always #5 Clk100M = ~Clk100M;

    // cyc = number of rising edges seen so far.
    int cyc = 0;
    always @(posedge Clk100M) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] blip;
        logic [1:0] rel;
        logic [1:0] level;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic push(input int c, input logic [1:0] b, input logic [1:0] r, input logic [1:0] l);
        exp_t e;
        e.cyc = c; e.blip = b; e.rel = r; e.level = l;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk100M);
    endtask

    // Monitor: any pulse on the outputs is matched against the next expected event.
    always @(negedge Clk100M) begin
        exp_t e;
        if (!Rst) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_fail++;
                $display("FAIL missed_event: nothing at cyc %0d, expected blip=%b rel=%b level=%b",
                         e.cyc, e.blip, e.rel, e.level);
            end
            if (btn_blip != 2'b00 || btn_rel_blip != 2'b00) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: cyc %0d blip=%b rel=%b level=%b, expected none",
                             cyc, btn_blip, btn_rel_blip, btn_level);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.blip !== btn_blip || e.rel !== btn_rel_blip ||
                        e.level !== btn_level) begin
                        n_fail++;
                        $display("FAIL event: got cyc %0d blip=%b rel=%b level=%b, expected cyc %0d blip=%b rel=%b level=%b",
                                 cyc, btn_blip, btn_rel_blip, btn_level,
                                 e.cyc, e.blip, e.rel, e.level);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, p, r, t;

        // Reset with both buttons held: outputs stay 0.
        tick(2);
        chk("reset_level", btn_level, 2'b00);
        chk("reset_blip", btn_blip, 2'b00);
        chk("reset_rel", btn_rel_blip, 2'b00);
        Rst = 1'b0;
        base = cyc;
        push(base + DB + 2, 2'b11, 2'b00, 2'b11);
        tick(10);
        chk("post_reset_level", btn_level, 2'b11);

        // Release both.
        btn_raw = 2'b00;
        base = cyc;
        push(base + DB + 2, 2'b00, 2'b11, 2'b00);
        tick(12);

        // Clean press on ch0, held 20 cycles, then release.
        btn_raw = 2'b01;
        base = cyc;
        p = base + DB + 2;
        r = base + 20 + DB + 2;
        push(p, 2'b01, 2'b00, 2'b01);
`ifdef BTN_AUTOREPEAT_EN
        t = p + RD;
        while (t < r) begin
            push(t, 2'b01, 2'b00, 2'b01);
            t += RP;
        end
`endif
        tick(10);
        chk("press_level_mid", btn_level, 2'b01);
        tick(10);
        btn_raw = 2'b00;
        push(r, 2'b00, 2'b01, 2'b00);
        tick(12);
        chk("release_level", btn_level, 2'b00);

        // Bounce on ch0: 1,1,1,0,1,1,1,1,1 then held; accepted 6 edges after sample index 4.
        base = cyc;
        push(base + 4 + DB + 2, 2'b01, 2'b00, 2'b01);
        push(base + 10 + DB + 2, 2'b00, 2'b01, 2'b00);
        for (int k = 0; k < 10; k++) begin
            btn_raw = (k == 3) ? 2'b00 : 2'b01;
            tick(1);
        end
        btn_raw = 2'b00;
        tick(12);

        // Simultaneous press and release on both channels.
        btn_raw = 2'b11;
        base = cyc;
        push(base + DB + 2, 2'b11, 2'b00, 2'b11);
        push(base + 8 + DB + 2, 2'b00, 2'b11, 2'b00);
        tick(8);
        btn_raw = 2'b00;
        tick(12);

        // 3-cycle glitch on ch1 is rejected.
        btn_raw = 2'b10;
        tick(3);
        btn_raw = 2'b00;
        tick(15);
        chk("glitch_level", btn_level, 2'b00);

        // Reset mid-operation with ch0 held: no release pulse, re-press afterwards.
        btn_raw = 2'b01;
        base = cyc;
        push(base + DB + 2, 2'b01, 2'b00, 2'b01);
        tick(8);
        chk("pre_reset_level", btn_level, 2'b01);
        Rst = 1'b1;
        tick(1);
        chk("midreset_level", btn_level, 2'b00);
        chk("midreset_rel", btn_rel_blip, 2'b00);
        tick(2);
        Rst = 1'b0;
        base = cyc;
        push(base + DB + 2, 2'b01, 2'b00, 2'b01);
        tick(8);
        btn_raw = 2'b00;
        base = cyc;
        push(base + DB + 2, 2'b00, 2'b01, 2'b00);
        tick(12);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending events expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
